// File: rtl/pc_pkg.sv
// Shared definitions for the program-address unit: action encoding and the
// stack-count width helper.
package pc_pkg;

  localparam logic [2:0] ACT_HOLD = 3'd0;
  localparam logic [2:0] ACT_INC  = 3'd1;
  localparam logic [2:0] ACT_LOAD = 3'd2;
  localparam logic [2:0] ACT_REL  = 3'd3;
  localparam logic [2:0] ACT_CALL = 3'd4;
  localparam logic [2:0] ACT_RET  = 3'd5;

  // Bits needed to hold values 0..v-1; never less than one bit.
  function automatic int clog2(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/pc_return_stack.sv
// Hardware return-address LIFO for the program-address unit. The count
// register is reset asynchronously; the entry storage is not reset.
module pc_return_stack
  import pc_pkg::*;
#(
  parameter int AW    = 8,
  parameter int DEPTH = 4,
  parameter int CW    = clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] pop_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          ovf,
  output logic          udf
);

  localparam int IW = clog2(DEPTH);

  logic [AW-1:0] mem [DEPTH];
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_dec;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic          do_push;
  logic          do_pop;

  assign full      = (count_reg == CW'(DEPTH));
  assign empty     = (count_reg == '0);
  assign count     = count_reg;
  assign count_dec = count_reg - CW'(1);
  assign wr_idx    = count_reg[IW-1:0];
  assign rd_idx    = count_dec[IW-1:0];

  // A pop in the same cycle as a push wins; the push is dropped entirely.
  assign do_pop  = pop && !empty;
  assign do_push = push && !pop && !full;
  assign ovf     = push && !pop && full;
  assign udf     = pop && empty;

  // Top-of-stack is read combinationally so a return completes in one cycle.
  assign pop_data = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (do_push && !rst) begin
      mem[wr_idx] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (do_pop) begin
      count_reg <= count_dec;
    end else if (do_push) begin
      count_reg <= count_reg + CW'(1);
    end
  end

endmodule

// File: rtl/program_addr_unit_stk.sv
// Program-address unit: PC register with increment, jump, call/return via a
// return stack, and optional relative branch enabled by PC_REL_BRANCH_EN.
module program_addr_unit_stk
  import pc_pkg::*;
#(
  parameter int          AW         = 8,
  parameter int          DEPTH      = 4,
  parameter logic [AW-1:0] RESET_ADDR = '0
) (
  input  logic          clk,
  input  logic          reset_p,
  input  logic          pc_inc,
  input  logic          load_pc,
  input  logic          call,
  input  logic          ret,
  input  logic          rel_br,
  input  logic          pc_rd_en,
  input  logic [AW-1:0] pc_in,
  input  logic [AW-1:0] rel_off,
  output logic [AW-1:0] pc_out,
  output logic [AW-1:0] pc_cur,
  output logic          stk_empty,
  output logic          stk_full,
  output logic          stk_err
);

  localparam int CW = clog2(DEPTH + 1);

  logic [AW-1:0] pc_reg;
  logic [AW-1:0] pc_next;
  logic [AW-1:0] pc_plus1;
  logic [AW-1:0] pop_data;
  logic [CW-1:0] stk_count;
  logic [2:0]    act;
  logic          err_reg;
  logic          full;
  logic          empty;
  logic          ovf;
  logic          udf;

`ifndef PC_REL_BRANCH_EN
  logic unused_rel;
  assign unused_rel = ^{rel_br, rel_off};
`endif

  assign pc_plus1 = pc_reg + AW'(1);

  always_comb begin
    act = ACT_HOLD;
    if (ret)          act = ACT_RET;
    else if (call)    act = ACT_CALL;
    else if (load_pc) act = ACT_LOAD;
`ifdef PC_REL_BRANCH_EN
    else if (rel_br)  act = ACT_REL;
`endif
    else if (pc_inc)  act = ACT_INC;
  end

  pc_return_stack #(
    .AW    (AW),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_stack (
    .clk       (clk),
    .rst       (reset_p),
    .push      (act == ACT_CALL),
    .pop       (act == ACT_RET),
    .push_data (pc_plus1),
    .pop_data  (pop_data),
    .count     (stk_count),
    .full      (full),
    .empty     (empty),
    .ovf       (ovf),
    .udf       (udf)
  );

  // Failed call/return leaves the PC where it was; only the error flag moves.
  always_comb begin
    pc_next = pc_reg;
    case (act)
      ACT_RET:  if (!empty) pc_next = pop_data;
      ACT_CALL: if (!full) pc_next = pc_in;
      ACT_LOAD: pc_next = pc_in;
`ifdef PC_REL_BRANCH_EN
      ACT_REL:  pc_next = pc_reg + rel_off;
`endif
      ACT_INC:  pc_next = pc_plus1;
      default:  pc_next = pc_reg;
    endcase
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      pc_reg  <= RESET_ADDR;
      err_reg <= 1'b0;
    end else begin
      pc_reg  <= pc_next;
      err_reg <= err_reg | ovf | udf;
    end
  end

  assign pc_cur    = pc_reg;
  assign pc_out    = pc_rd_en ? pc_reg : {AW{1'bz}};
  assign stk_empty = (stk_count == '0);
  assign stk_full  = (stk_count == CW'(DEPTH));
  assign stk_err   = err_reg;

endmodule

// File: tb/tb_program_addr_unit_stk.sv
// Self-checking bench for program_addr_unit_stk (AW=8, DEPTH=4): directed
// steps followed by random traffic against a queue-based reference model.
module tb_program_addr_unit_stk;

  logic       clk = 1'b0;
  logic       reset_p = 1'b1;
  logic       pc_inc = 1'b0, load_pc = 1'b0, call = 1'b0, ret = 1'b0, rel_br = 1'b0;
  logic       pc_rd_en = 1'b0;
  logic [7:0] pc_in = 8'h00, rel_off = 8'h00;
  logic [7:0] pc_out, pc_cur;
  logic       stk_empty, stk_full, stk_err;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [7:0] m_pc;
  logic [7:0] m_stack[$];
  logic       m_err;

  program_addr_unit_stk #(.AW(8), .DEPTH(4), .RESET_ADDR(8'h00)) dut (
    .clk       (clk),
    .reset_p   (reset_p),
    .pc_inc    (pc_inc),
    .load_pc   (load_pc),
    .call      (call),
    .ret       (ret),
    .rel_br    (rel_br),
    .pc_rd_en  (pc_rd_en),
    .pc_in     (pc_in),
    .rel_off   (rel_off),
    .pc_out    (pc_out),
    .pc_cur    (pc_cur),
    .stk_empty (stk_empty),
    .stk_full  (stk_full),
    .stk_err   (stk_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] exp_out;
    exp_out = pc_rd_en ? m_pc : 8'hzz;
    check({tag, ".pc_cur"}, pc_cur, m_pc);
    check({tag, ".pc_out"}, pc_out, exp_out);
    check({tag, ".empty"}, {7'd0, stk_empty}, {7'd0, m_stack.size() == 0});
    check({tag, ".full"}, {7'd0, stk_full}, {7'd0, m_stack.size() == 4});
    check({tag, ".err"}, {7'd0, stk_err}, {7'd0, m_err});
  endtask

  // Behavioural rule set: priority ret > call > load > rel > inc > hold.
  task automatic model_step();
    if (ret) begin
      if (m_stack.size() == 0) m_err = 1'b1;
      else m_pc = m_stack.pop_back();
    end else if (call) begin
      if (m_stack.size() == 4) m_err = 1'b1;
      else begin
        m_stack.push_back(8'(m_pc + 8'd1));
        m_pc = pc_in;
      end
    end else if (load_pc) begin
      m_pc = pc_in;
`ifdef PC_REL_BRANCH_EN
    end else if (rel_br) begin
      m_pc = 8'(m_pc + rel_off);
`endif
    end else if (pc_inc) begin
      m_pc = 8'(m_pc + 8'd1);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic c, input logic l,
                      input logic b, input logic i, input logic rd,
                      input logic [7:0] tgt, input logic [7:0] off);
    ret = r; call = c; load_pc = l; rel_br = b; pc_inc = i;
    pc_rd_en = rd; pc_in = tgt; rel_off = off;
    @(posedge clk);
    #1;
    model_step();
    $display("step %-10s ret=%b call=%b load=%b rel=%b inc=%b in=%h off=%h -> pc=%h exp=%h",
             tag, r, c, l, b, i, tgt, off, pc_cur, m_pc);
    check_all(tag);
  endtask

  task automatic do_reset();
    ret = 0; call = 0; load_pc = 0; rel_br = 0; pc_inc = 0;
    @(negedge clk);
    reset_p = 1'b1;
    #2;
    m_pc = 8'h00; m_stack.delete(); m_err = 1'b0;
    @(negedge clk);
    reset_p = 1'b0;
  endtask

  initial begin
    m_pc = 8'h00; m_err = 1'b0;
    pc_rd_en = 1'b1;
    #12;
    check_all("reset");
    do_reset();
    check_all("post_rst");

    // Increment with bus enabled, then bus released
    step("inc1", 0, 0, 0, 0, 1, 1, 8'h00, 8'h00);
    step("inc2", 0, 0, 0, 0, 1, 1, 8'h00, 8'h00);
    step("inc3", 0, 0, 0, 0, 1, 1, 8'h00, 8'h00);
    step("bus_z", 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);

    // Load near the top and wrap
    step("load_fe", 0, 0, 1, 0, 0, 1, 8'hFE, 8'h00);
    step("inc_ff", 0, 0, 0, 0, 1, 1, 8'h00, 8'h00);
    step("wrap_00", 0, 0, 0, 0, 1, 1, 8'h00, 8'h00);

    // Nested call/return
    step("load_10", 0, 0, 1, 0, 0, 1, 8'h10, 8'h00);
    step("call_40", 0, 1, 0, 0, 0, 1, 8'h40, 8'h00);
    step("call_80", 0, 1, 0, 0, 0, 1, 8'h80, 8'h00);
    step("ret_41", 1, 0, 0, 0, 0, 1, 8'h00, 8'h00);
    step("ret_11", 1, 0, 0, 0, 0, 1, 8'h00, 8'h00);

    // Fill and overflow
    for (int k = 0; k < 4; k++) step("fill", 0, 1, 0, 0, 0, 1, 8'(8'h20 + k), 8'h00);
    step("ovf_99", 0, 1, 0, 0, 0, 1, 8'h99, 8'h00);
    step("ret_ovf", 1, 0, 0, 0, 0, 1, 8'h00, 8'h00);

    // Underflow and call+ret collision
    do_reset();
    step("udf", 1, 0, 0, 0, 0, 1, 8'h00, 8'h00);
    do_reset();
    step("call_a", 0, 1, 0, 0, 0, 1, 8'h50, 8'h00);
    step("call_ret", 1, 1, 0, 0, 0, 1, 8'h77, 8'h00);

    // Relative branch (or fall-through to increment when disabled)
    step("load_20", 0, 0, 1, 0, 0, 1, 8'h20, 8'h00);
    step("rel_f0", 0, 0, 0, 1, 1, 1, 8'h00, 8'hF0);

    // Reset mid-call: the pending push must not happen
    step("load_33", 0, 0, 1, 0, 0, 1, 8'h33, 8'h00);
    call = 1; pc_in = 8'h44;
    @(negedge clk);
    reset_p = 1'b1;
    #1;
    m_pc = 8'h00; m_stack.delete(); m_err = 1'b0;
    check_all("async_rst");
    @(posedge clk); #1;
    check_all("rst_hold");
    call = 0;
    @(negedge clk);
    reset_p = 1'b0;

    // Random traffic, biased toward stack activity
    for (int n = 0; n < 400; n++) begin
      step("rand",
           $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           8'($urandom), 8'($urandom));
      if ($urandom_range(0, 60) == 0) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
